// File: rtl/pattern_gen_pkg.sv
// rtl/pattern_gen_pkg.sv - shared types and constants for the pattern FIFO write generator
package pattern_gen_pkg;

  typedef enum logic [2:0] {
    MODE_INCR   = 3'd0,
    MODE_DECR   = 3'd1,
    MODE_ZF     = 3'd2,
    MODE_5A     = 3'd3,
    MODE_PRBS31 = 3'd4,
    MODE_WALK1  = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  // x^31 + x^28 + 1
  localparam int PRBS_TAP_A = 31;
  localparam int PRBS_TAP_B = 28;

  localparam logic [3:0] NIBBLE_5 = 4'h5;
  localparam logic [3:0] NIBBLE_A = 4'hA;

  // Codes 6 and 7 fall back to incrementing.
  function automatic mode_t decode_mode(input logic [2:0] p);
    if (p > 3'd5) return MODE_INCR;
    return mode_t'(p);
  endfunction

endpackage

// File: rtl/pattern_word_gen.sv
// rtl/pattern_word_gen.sv - word(k) mux and PRBS-31 register for the pattern generator
module pattern_word_gen
  import pattern_gen_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          BLK_LOG2  = 16,
  parameter int          WALK_W    = 5,
  parameter logic [30:0] PRBS_SEED = 31'h7FFF_FFFF
) (
  input  logic                digiclk,
  input  logic                reset,
  input  mode_t               mode,
  input  logic [DATA_W-1:0]   base,
  input  logic [BLK_LOG2-1:0] k,
  input  logic [WALK_W-1:0]   walk_pos,
  input  logic                advance,
  output logic [DATA_W-1:0]   word
);

  logic [30:0]       prbs_q;
  logic [30:0]       prbs_nxt;
  logic [DATA_W-1:0] prbs_word;
  logic [DATA_W-1:0] incr_word;
  logic [3:0]        nib;

  // DATA_W serial shifts per word; the word is the register after stepping.
  always_comb begin
    prbs_nxt = prbs_q;
    for (int i = 0; i < DATA_W; i++) begin
      prbs_nxt = {prbs_nxt[29:0], prbs_nxt[PRBS_TAP_A-1] ^ prbs_nxt[PRBS_TAP_B-1]};
    end
    prbs_word = DATA_W'(64'(prbs_nxt));
  end

  always_ff @(posedge digiclk) begin
    if (reset) begin
      prbs_q <= PRBS_SEED;
    end else if (advance) begin
      prbs_q <= prbs_nxt;
    end
  end

  always_comb begin
    incr_word = base + DATA_W'(k);
    nib       = k[1] ? NIBBLE_A : NIBBLE_5;
    word      = '0;
    unique case (mode)
      MODE_INCR:   word = incr_word;
      MODE_DECR:   word = ~incr_word;
      MODE_ZF:     word = {DATA_W{k[1]}};
      MODE_5A:     word = DATA_W'({16{nib}});
      MODE_PRBS31: word = prbs_word;
      MODE_WALK1:  word = DATA_W'(1) << walk_pos;
      default:     word = '0;
    endcase
  end

endmodule

// File: rtl/pattern_gen_fifo_ctrl.sv
// rtl/pattern_gen_fifo_ctrl.sv - block pattern writer for PATTERN_FIFO; PATTERN_ERR_INJ_EN adds err_inject
module pattern_gen_fifo_ctrl
  import pattern_gen_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          BLK_LOG2  = 16,
  parameter int          BLK_CNT_W = 16,
  parameter logic [30:0] PRBS_SEED = 31'h7FFF_FFFF
) (
  input  logic                 digiclk,
  input  logic                 reset,
  input  logic [2:0]           pattern,
  input  logic                 pattern_init,
  input  logic                 pattern_full,
  input  logic                 pattern_empty,
`ifdef PATTERN_ERR_INJ_EN
  input  logic                 err_inject,
`endif
  output logic                 pattern_we,
  output logic [DATA_W-1:0]    pattern_data,
  output logic                 busy,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic                 blk_done
);

  localparam int WALK_W = $clog2(DATA_W);

  state_t              state, state_nxt;
  mode_t               mode_q;
  logic                armed, pending, empty_d;
  logic                start, write, last, err_flip;
  logic [DATA_W-1:0]   base_q, base_nxt, word;
  logic [BLK_LOG2-1:0] k_q;
  logic [WALK_W-1:0]   walk_q;

  // Before arming only pattern_init starts a block; afterwards only FIFO drain does.
  assign start    = armed ? (pattern_empty & ~empty_d) : pattern_init;
  assign last     = (k_q == '1);
  assign base_nxt = DATA_W'(blk_cnt) << BLK_LOG2;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    write     = 1'b0;
    unique case (state)
      IDLE:    if (start || pending) state_nxt = RUN;
      RUN: begin
        if (pattern_full) begin
          state_nxt = STALL;
        end else begin
          write = 1'b1;
          if (last) state_nxt = IDLE;
        end
      end
      STALL:   if (!pattern_full) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge digiclk) begin
    if (reset) begin
      state        <= IDLE;
      mode_q       <= MODE_INCR;
      armed        <= 1'b0;
      pending      <= 1'b0;
      empty_d      <= 1'b0;
      base_q       <= '0;
      k_q          <= '0;
      walk_q       <= '0;
      pattern_we   <= 1'b0;
      pattern_data <= '0;
      blk_cnt      <= '0;
      blk_done     <= 1'b0;
    end else begin
      state      <= state_nxt;
      empty_d    <= pattern_empty;
      pattern_we <= write;
      blk_done   <= 1'b0;
      if (pattern_init) armed <= 1'b1;

      if (state == IDLE) begin
        if (start || pending) begin
          if (!start) pending <= 1'b0;
          mode_q <= decode_mode(pattern);
          base_q <= base_nxt;
          k_q    <= '0;
          walk_q <= '0;
        end
      end else if (start) begin
        pending <= 1'b1;
      end

      if (write) begin
        pattern_data <= word ^ DATA_W'(err_flip);
        k_q          <= k_q + 1'b1;
        walk_q       <= (walk_q == WALK_W'(DATA_W - 1)) ? '0 : walk_q + 1'b1;
        if (last) begin
          blk_cnt  <= blk_cnt + 1'b1;
          blk_done <= 1'b1;
        end
      end
    end
  end

`ifdef PATTERN_ERR_INJ_EN
  logic err_arm;

  // One-shot: consumed by the next real write, so it survives any stall.
  always_ff @(posedge digiclk) begin
    if (reset) begin
      err_arm <= 1'b0;
    end else begin
      err_arm <= err_inject | (err_arm & ~write);
    end
  end

  assign err_flip = err_arm;
`else
  assign err_flip = 1'b0;
`endif

  pattern_word_gen #(
    .DATA_W   (DATA_W),
    .BLK_LOG2 (BLK_LOG2),
    .WALK_W   (WALK_W),
    .PRBS_SEED(PRBS_SEED)
  ) u_word_gen (
    .digiclk (digiclk),
    .reset   (reset),
    .mode    (mode_q),
    .base    (base_q),
    .k       (k_q),
    .walk_pos(walk_q),
    .advance (write && (mode_q == MODE_PRBS31)),
    .word    (word)
  );

endmodule

// File: doc/pattern_gen_fifo_ctrl.md
Name: pattern_gen_fifo_ctrl

Overview:
Parametrised successor to the PATTERN_FIFO write controller. It generates fixed-length blocks of test words into a pattern FIFO, with configurable word width, block length and six pattern modes (adds PRBS-31 and walking-one). It honours FIFO almost-full backpressure and queues one pending refill request. It sits between the ROC command decoder (pattern_init, i.e. FIFO_WRITE_MEM) and the PATTERN_FIFO write port.

Parameters:
DATA_W, 32, pattern word width in bits (legal range 8..64).
BLK_LOG2, 16, log2 of words per block; block length is 2^BLK_LOG2.
BLK_CNT_W, 16, width of the block counter; wraps at 2^BLK_CNT_W.
PRBS_SEED, 31'h7FFF_FFFF, PRBS-31 seed; must be non-zero.

Ports:
digiclk  in  1  clock
reset  in  1  synchronous reset, active-high
pattern  in  3  mode: 0 INCR, 1 DECR, 2 0s/Fs, 3 5s/As, 4 PRBS31, 5 WALK1; 6 and 7 are treated as 0
pattern_init  in  1  FIFO_WRITE_MEM command pulse
pattern_full  in  1  PATTERN_FIFO almost-full; stalls writes
pattern_empty  in  1  PATTERN_FIFO empty
pattern_we  out  1  PATTERN_FIFO write enable, registered
pattern_data  out  DATA_W  PATTERN_FIFO write data, registered
busy  out  1  high while a block is in progress
blk_cnt  out  BLK_CNT_W  number of completed blocks
blk_done  out  1  one-cycle pulse after the last word of a block

Behaviour:
- Reset values: pattern_we=0, pattern_data=0, busy=0, blk_cnt=0, blk_done=0. Internal state also clears: armed=0, pending=0, empty_d=0, PRBS register=PRBS_SEED, state=IDLE.
- Start event:
  - Before the block is armed: start = pattern_init; the first pattern_init also sets armed.
  - After armed: start = rising edge of pattern_empty (pattern_empty & ~empty_d).
  - pattern_init after armed is ignored.
- States: IDLE, RUN, STALL.
  - IDLE: on start, latch mode and base = blk_cnt << BLK_LOG2 (truncated to DATA_W), set k=0, go to RUN. Otherwise, if pending=1, clear pending and start.
  - RUN: if pattern_full=1, go to STALL with pattern_we=0. Otherwise drive pattern_we=1 and pattern_data=word(k), then k++. When k reaches 2^BLK_LOG2-1 and that word is written: blk_cnt++, blk_done=1 next cycle, go to IDLE.
  - STALL: pattern_we=0 and all counters hold. Return to RUN the cycle after pattern_full falls.
- Latency: a start sampled at edge N gives the first pattern_we=1 on the cycle after edge N+1, i.e. two registered stages. Zero-stall throughput is 1 word per cycle. Block duration is exactly 2^BLK_LOG2 + 1 cycles, IDLE included.
- word(k) per latched mode:
  - INCR: base + k (mod 2^DATA_W).
  - DECR: all-ones - (base + k).
  - 0s/Fs: all-zero when k[1]=0, all-ones when k[1]=1.
  - 5s/As: replicated 4'h5 when k[1]=0, 4'hA when k[1]=1.
  - PRBS31: polynomial x^31+x^28+1, DATA_W serial steps per word, output is the low DATA_W bits (zero-extended when DATA_W>31). The register persists across blocks and resets only on reset.
  - WALK1: one-hot with bit (k mod DATA_W) set.
- Mode changes on `pattern` mid-block take effect only at the next block start.
- A start event while busy sets pending; a further event while pending=1 is dropped (saturates at one). The pending block starts in the IDLE cycle immediately after blk_done.
- blk_cnt wraps to 0 after 2^BLK_CNT_W-1; base wraps modulo 2^DATA_W.
- Reset asserted mid-block aborts it on the same edge; no further writes occur and no blk_done is issued.

Optional Feature:
PATTERN_ERR_INJ_EN
- Defined: adds input err_inject (1 bit). A pulse arms a one-shot that inverts bit 0 of the next word written, then self-clears. The arm survives STALL.
- Undefined: the port is absent and data is never corrupted.

Decomposition:
- Package pattern_gen_pkg holds:
  - the mode enum (INCR..WALK1);
  - the state enum (IDLE, RUN, STALL);
  - PRBS31 taps (31, 28);
  - nibble constants 4'h5 and 4'hA.
- One sub-module, pattern_word_gen: a combinational word(k) mux plus the sequential PRBS register, advanced only when enabled.

Test Plan:
Bench setup: DATA_W=32, BLK_LOG2=4, pattern_full=0 unless stated.
- Reset, mode 0, pattern_init pulse -> 16 writes 0x0..0xF, blk_done pulse, blk_cnt=1; a second pattern_init produces no writes.
- Empty rising edge, mode 1, blk_cnt=1 -> writes 0xFFFFFFEF down to 0xFFFFFFE0.
- Mode 3 -> 0x55555555 x2, 0xAAAAAAAA x2, repeating; mode 5 -> 0x1, 0x2, 0x4, ... 0x8000.
- Hold pattern_full high for 5 cycles at word 7 -> no writes during the hold; sequence resumes at word 7 with no gaps or duplicates.
- Two empty edges during a block -> exactly one back-to-back extra block follows; a third edge is dropped.
- Reset asserted at word 9 -> pattern_we=0 next cycle, blk_cnt=0, no blk_done; mode 4 after restart -> first word equals the golden PRBS31 model from PRBS_SEED.
